pipeline_stage_elastic: RTL and testbench
=========================================

// Module: pipeline_stage_elastic
// PURPOSE
//  Parametrised successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Provides one generic, width-agnostic stage register with a valid/ready handshake,
//  an optional 2-entry skid buffer, synchronous flush-to-NOP, a legacy freeze (stall),
//  and saturating stall/bubble performance counters.
//  It sits between any two pipeline stages. The upstream stage packs its control and
//  data fields into in_data, and the downstream stage unpacks out_data.
// PARAMETERS
//  DATA_W     128  width of the packed stage payload (control + data fields)
//  NOP_VALUE  '0   payload presented on out_data when empty, after reset and after flush
//  SKID_EN    1    1: 2-entry skid buffer with registered in_ready; 0: single entry with combinational ready
//  CNT_W      16   width of each performance counter
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       asynchronous reset, active high
//  flush      in   1       synchronous discard of all held entries
//  freeze     in   1       legacy stall: hold all state, block both handshakes
//  cnt_clr    in   1       synchronous clear of both counters
//  in_valid   in   1       upstream presents in_data
//  in_ready   out  1       stage can accept this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       out_data holds a real instruction
//  out_ready  in   1       downstream consumes this cycle
//  out_data   out  DATA_W  head entry (main register)
//  occupancy  out  2       entries held: 0, 1 or 2 (2 only when SKID_EN=1)
//  stall_cnt  out  CNT_W   cycles with out_valid=1 and out_ready=0
//  bubble_cnt out  CNT_W   cycles with out_valid=0 and out_ready=1
// BEHAVIOUR
//  Handshake events
//  - Accept (in_fire) = in_valid & in_ready. Consume (out_fire) = out_valid & out_ready.
//  - Payload accepted at edge N appears on out_data after edge N. Latency is 1 cycle.
//  - Throughput is 1 entry per cycle when out_ready is held at 1.
//  Reset (asynchronous, RST=1)
//  - state=EMPTY; out_data=NOP_VALUE; skid register=NOP_VALUE.
//  - out_valid=0; occupancy=0; both counters=0.
//  - in_ready=0 while RST is asserted.
//  - Reset takes effect immediately, mid-operation included.
//  Output and ready equations
//  - out_valid = (state != EMPTY) & ~freeze.
//  - SKID_EN=1: in_ready = (state != TWO) & ~freeze. Depends only on flops and freeze.
//  - SKID_EN=0: in_ready = ((state == EMPTY) | out_ready) & ~freeze. Combinational through out_ready.
//  State machine (SKID_EN=0 never enters TWO)
//  - EMPTY: in_fire -> ONE, main <= in_data.
//  - ONE:   in_fire & out_fire -> ONE, main <= in_data.
//           in_fire & ~out_fire -> TWO, skid <= in_data.
//           out_fire & ~in_fire -> EMPTY, main <= NOP_VALUE.
//           neither -> hold.
//  - TWO:   out_fire -> ONE, main <= skid, skid <= NOP_VALUE.
//           otherwise hold (in_ready=0).
//  - Entries leave in arrival order. No loss or duplication.
//  Priority, highest first: RST > flush > freeze > handshake
//  - flush: next state EMPTY; main and skid <= NOP_VALUE.
//    An in_fire in the same cycle is discarded. Counters are unaffected by flush.
//  - freeze (without flush): state and payload registers hold.
//    out_valid and in_ready are forced to 0. Counters do not increment.
//  Counters
//  - Evaluated on visible out_valid and out_ready each non-frozen cycle.
//  - Each counter saturates at all-ones.
//  - cnt_clr zeroes both counters and overrides an increment in the same cycle.
//  occupancy encoding: EMPTY=0, ONE=1, TWO=2.
// TESTING
//  1. Stream: SKID_EN=1, out_ready=1, in_valid=1, data 1..8 on consecutive cycles
//     -> out_data 1..8, each 1 cycle after accept; out_valid continuously 1; bubble_cnt=0.
//  2. Backpressure: out_ready=0, push A then B
//     -> occupancy=2, in_ready=0, C held upstream; raise out_ready
//     -> A, B, C delivered in order; stall_cnt equals the number of blocked cycles.
//  3. Flush: occupancy=2 and in_valid=1 with D in the same cycle as flush
//     -> next cycle occupancy=0, out_valid=0, out_data=NOP_VALUE; D never emerges.
//  4. Freeze: occupancy=1 holding E, freeze=1 for 3 cycles with out_ready=1
//     -> out_valid=0, in_ready=0, counters unchanged; freeze=0 -> E delivered once.
//  5. Async reset: assert RST between clock edges with occupancy=2
//     -> out_valid=0, occupancy=0, out_data=NOP_VALUE before the next edge.
//  6. Saturation and SKID_EN=0: CNT_W=4, out_ready=0, valid held for 20 cycles -> stall_cnt=15.
//     SKID_EN=0: in_ready follows out_ready in the same cycle; occupancy never exceeds 1.

Source files
------------

// File: rtl/pipeline_stage_elastic.sv
// Generic elastic stage register with optional 2-entry skid buffer, flush, freeze and perf counters.
// Latency 1 cycle; backpressure via in_ready (registered when SKID_EN=1, combinational through out_ready otherwise).
module pipeline_stage_elastic #(
  parameter int                DATA_W    = 128,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter int                CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              freeze,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  // RST gates in_ready so upstream never fires into a stage held in reset
  always_comb begin
    out_valid = (state != EMPTY) & ~freeze;
    if (SKID_EN)
      in_ready = (state != TWO) & ~freeze & ~RST;
    else
      in_ready = ((state == EMPTY) | out_ready) & ~freeze & ~RST;
  end

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (!freeze) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          // in_fire without out_fire is only reachable with the skid buffer enabled
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= TWO;
            skid_q <= in_data;
          end else if (out_fire) begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
          end
        end
        TWO: begin
          if (out_fire) begin
            state  <= ONE;
            main_q <= skid_q;
            skid_q <= NOP_VALUE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= NOP_VALUE;
          skid_q <= NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!freeze) begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid && out_ready && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: skid (CNT_W=16) and no-skid (CNT_W=4) instances share stimulus.
module tb_pipeline_stage_elastic;

  localparam logic [15:0] N = 16'hDEAD;

  logic        CLK, RST, flush, freeze, cnt_clr, in_valid, out_ready;
  logic [15:0] in_data;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0] a_out_data, b_out_data;
  logic [1:0]  a_occ, b_occ;
  logic [15:0] a_stall, a_bubble;
  logic [3:0]  b_stall, b_bubble;

  pipeline_stage_elastic #(.DATA_W(16), .NOP_VALUE(N), .SKID_EN(1'b1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  pipeline_stage_elastic #(.DATA_W(16), .NOP_VALUE(N), .SKID_EN(1'b0), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .flush(flush), .freeze(freeze), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a bounded FIFO (capacity 2 for instance a, 1 for b) plus saturating counters
  int          m_n[2];
  logic [15:0] m_e[2][2];
  int          m_st[2];
  int          m_bu[2];
  int          m_max[2] = '{65535, 15};

  function automatic bit m_ov(int i);
    return m_n[i] > 0 && !freeze;
  endfunction

  function automatic bit m_ir(int i);
    if (i == 0) return m_n[i] < 2 && !freeze;
    return (m_n[i] == 0 || out_ready) && !freeze;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_n[i] = 0; m_st[i] = 0; m_bu[i] = 0;
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      string p = (i == 0) ? "a" : "b";
      chk({p, "_out_valid"}, (i == 0) ? a_out_valid : b_out_valid, m_ov(i));
      chk({p, "_out_data"}, (i == 0) ? a_out_data : b_out_data, (m_n[i] > 0) ? m_e[i][0] : N);
      chk({p, "_in_ready"}, (i == 0) ? a_in_ready : b_in_ready, m_ir(i));
      chk({p, "_occupancy"}, (i == 0) ? a_occ : b_occ, m_n[i]);
      chk({p, "_stall_cnt"}, (i == 0) ? a_stall : 16'(b_stall), m_st[i]);
      chk({p, "_bubble_cnt"}, (i == 0) ? a_bubble : 16'(b_bubble), m_bu[i]);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit ov = m_ov(i);
      bit inf = in_valid && m_ir(i);
      bit outf = ov && out_ready;
      if (cnt_clr) begin
        m_st[i] = 0; m_bu[i] = 0;
      end else if (!freeze) begin
        if (ov && !out_ready && m_st[i] < m_max[i]) m_st[i]++;
        if (!ov && out_ready && m_bu[i] < m_max[i]) m_bu[i]++;
      end
      if (flush) m_n[i] = 0;
      else if (!freeze) begin
        if (outf) begin
          m_e[i][0] = m_e[i][1];
          m_n[i]--;
        end
        if (inf) begin
          m_e[i][m_n[i]] = in_data;
          m_n[i]++;
        end
      end
    end
  endtask

  typedef struct {
    bit fl, fz, cl, iv;
    logic [15:0] d;
    bit ordy;
    bit ov;
    logic [15:0] od;
    int occ;
    bit ir;
    int st, bu;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl[NV];

  function automatic vec_t v(bit fl, bit fz, bit cl, bit iv, logic [15:0] d, bit ordy,
                             bit ov, logic [15:0] od, int occ, bit ir, int st, int bu);
    vec_t r;
    r.fl = fl; r.fz = fz; r.cl = cl; r.iv = iv; r.d = d; r.ordy = ordy;
    r.ov = ov; r.od = od; r.occ = occ; r.ir = ir; r.st = st; r.bu = bu;
    return r;
  endfunction

  // Called at a negedge; drives, checks mid-cycle, advances one clock, returns at the next negedge
  task automatic step(input bit fl, input bit fz, input bit cl, input bit iv,
                      input logic [15:0] d, input bit ordy, input int row);
    flush = fl; freeze = fz; cnt_clr = cl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    check_model();
    if (row >= 0) begin
      chk($sformatf("row%0d_out_valid", row), a_out_valid, tbl[row].ov);
      chk($sformatf("row%0d_out_data", row), a_out_data, tbl[row].od);
      chk($sformatf("row%0d_occupancy", row), a_occ, tbl[row].occ);
      chk($sformatf("row%0d_in_ready", row), a_in_ready, tbl[row].ir);
      chk($sformatf("row%0d_stall_cnt", row), a_stall, tbl[row].st);
      chk($sformatf("row%0d_bubble_cnt", row), a_bubble, tbl[row].bu);
    end
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  initial begin
    // stream 1..8, backpressure A/B/C, flush with full and single entry, freeze holding E, clear
    tbl[0] = v(0,0,1,1,16'd1,0, 0,N,0,1,0,0);
    for (int k = 1; k <= 7; k++) tbl[k] = v(0,0,0,1,16'(k+1),1, 1,16'(k),1,1,0,0);
    tbl[8]  = v(0,0,0,0,16'h0,1,    1,16'd8,1,1,0,0);
    tbl[9]  = v(0,0,0,0,16'h0,0,    0,N,0,1,0,0);
    tbl[10] = v(0,0,0,1,16'h00A1,0, 0,N,0,1,0,0);
    tbl[11] = v(0,0,0,1,16'h00B2,0, 1,16'h00A1,1,1,0,0);
    tbl[12] = v(0,0,0,1,16'h00C3,0, 1,16'h00A1,2,0,1,0);
    tbl[13] = v(0,0,0,1,16'h00C3,0, 1,16'h00A1,2,0,2,0);
    tbl[14] = v(0,0,0,1,16'h00C3,1, 1,16'h00A1,2,0,3,0);
    tbl[15] = v(0,0,0,1,16'h00C3,1, 1,16'h00B2,1,1,3,0);
    tbl[16] = v(0,0,0,0,16'h0,1,    1,16'h00C3,1,1,3,0);
    tbl[17] = v(0,0,0,0,16'h0,0,    0,N,0,1,3,0);
    tbl[18] = v(0,0,0,1,16'h00D1,0, 0,N,0,1,3,0);
    tbl[19] = v(0,0,0,1,16'h00D2,0, 1,16'h00D1,1,1,3,0);
    tbl[20] = v(1,0,0,1,16'h00DD,0, 1,16'h00D1,2,0,4,0);
    tbl[21] = v(0,0,0,0,16'h0,0,    0,N,0,1,5,0);
    tbl[22] = v(0,0,0,1,16'h0A5A,0, 0,N,0,1,5,0);
    tbl[23] = v(1,0,0,1,16'h0B5B,0, 1,16'h0A5A,1,1,5,0);
    tbl[24] = v(0,0,0,0,16'h0,1,    0,N,0,1,6,0);
    tbl[25] = v(0,0,0,1,16'h0EEE,0, 0,N,0,1,6,1);
    tbl[26] = v(0,1,0,0,16'h0,1,    0,16'h0EEE,1,0,6,1);
    tbl[27] = v(0,1,0,1,16'h00FF,1, 0,16'h0EEE,1,0,6,1);
    tbl[28] = v(0,1,0,0,16'h0,1,    0,16'h0EEE,1,0,6,1);
    tbl[29] = v(0,0,0,0,16'h0,1,    1,16'h0EEE,1,1,6,1);
    tbl[30] = v(0,0,0,0,16'h0,1,    0,N,0,1,6,1);
    tbl[31] = v(0,0,1,0,16'h0,1,    0,N,0,1,6,2);
    tbl[32] = v(0,0,0,0,16'h0,0,    0,N,0,1,0,0);

    RST = 1'b1; flush = 0; freeze = 0; cnt_clr = 0; in_valid = 0; in_data = '0; out_ready = 0;
    model_reset();
    #3;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_occupancy", a_occ, 0);
    chk("rst_a_out_data", a_out_data, N);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_a_stall_cnt", a_stall, 0);
    chk("rst_a_bubble_cnt", a_bubble, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_b_out_data", b_out_data, N);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    for (int r = 0; r < NV; r++)
      step(tbl[r].fl, tbl[r].fz, tbl[r].cl, tbl[r].iv, tbl[r].d, tbl[r].ordy, r);

    // asynchronous reset between edges with two entries held
    step(0,0,0,1,16'h1111,0,-1);
    step(0,0,0,1,16'h2222,0,-1);
    chk("pre_rst_a_occupancy", a_occ, 2);
    in_valid = 0;
    #2 RST = 1'b1;
    #1;
    chk("arst_a_out_valid", a_out_valid, 0);
    chk("arst_a_occupancy", a_occ, 0);
    chk("arst_a_out_data", a_out_data, N);
    chk("arst_a_in_ready", a_in_ready, 0);
    chk("arst_b_occupancy", b_occ, 0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;

    // saturation of the 4-bit counter, and combinational ready without skid
    step(0,0,1,1,16'h0055,0,-1);
    for (int k = 0; k < 20; k++) step(0,0,0,1,16'h0066,0,-1);
    chk("sat_b_stall_cnt", b_stall, 15);
    chk("sat_a_stall_cnt", a_stall, 20);
    out_ready = 1;
    #1 chk("b_in_ready_follows_1", b_in_ready, 1);
    out_ready = 0;
    #1 chk("b_in_ready_follows_0", b_in_ready, 0);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 1) == 1, 16'($urandom_range(0, 65535)), $urandom_range(0, 9) < 7, -1);
      chk("b_occupancy_le1", b_occ <= 2'd1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
